time_entry_ctrl: RTL and testbench



---
 rtl/time_entry_pkg.sv | 84 ++++++++
 rtl/time_entry_ctrl_keypad_event.sv | 39 +++
 rtl/time_entry_ctrl.sv | 169 ++++++++++++++++
 tb/tb_time_entry_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/time_entry_pkg.sv
// Shared types, keypad layout and HH:MM limits for the time entry controller.
package time_entry_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTRY  = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        ERROR  = 3'd4
    } state_t;

    // Key codes: 0..9 are BCD digits, the rest are control keys
    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_CLEAR = 4'hA;
    localparam key_code_t KEY_ENTER = 4'hB;
    localparam key_code_t KEY_NONE  = 4'hF;

    // Keypad layout:
    //   row0: 1 2 3 A
    //   row1: 4 5 6 B
    //   row2: 7 8 9 C
    //   row3: * 0 # D
    localparam logic [1:0] ROW_BOTTOM = 2'd3;
    localparam logic [1:0] COL_LETTER = 2'd3;
    localparam logic [1:0] COL_STAR   = 2'd0;
    localparam logic [1:0] COL_ZERO   = 2'd1;
    localparam logic [1:0] COL_HASH   = 2'd2;

    // HH:MM digit limits
    localparam logic [3:0] MAX_H1      = 4'd2;
    localparam logic [3:0] MAX_H0_HIGH = 4'd3;
    localparam logic [3:0] MAX_M1      = 4'd5;
    localparam logic [3:0] MAX_DIGIT   = 4'd9;

    // Number of BCD digits in a complete entry
    localparam logic [2:0] FULL_COUNT = 3'd4;

    // Translate a keypad position to a key code
    function automatic key_code_t decode_key(input logic [1:0] row, input logic [1:0] col);
        key_code_t code;
        if (col == COL_LETTER) begin
            code = KEY_NONE;
        end else if (row == ROW_BOTTOM) begin
            case (col)
                COL_STAR: code = KEY_CLEAR;
                COL_ZERO: code = 4'd0;
                COL_HASH: code = KEY_ENTER;
                default:  code = KEY_NONE;
            endcase
        end else begin
            // Rows 0..2 hold digits 1..9 laid out three per row
            code = (key_code_t'(row) * 4'd3) + key_code_t'(col) + 4'd1;
        end
        return code;
    endfunction

    function automatic logic is_digit(input key_code_t code);
        return (code <= MAX_DIGIT);
    endfunction

    // A BCD HHMM value is a legal 24-hour time of day
    function automatic logic time_is_valid(input logic [15:0] v);
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic       hours_ok;
        h1 = v[15:12];
        h0 = v[11:8];
        m1 = v[7:4];
        m0 = v[3:0];
        if (h1 < MAX_H1) begin
            hours_ok = (h0 <= MAX_DIGIT);
        end else if (h1 == MAX_H1) begin
            hours_ok = (h0 <= MAX_H0_HIGH);
        end else begin
            hours_ok = 1'b0;
        end
        return hours_ok && (m1 <= MAX_M1) && (m0 <= MAX_DIGIT);
    endfunction

endpackage

// File: rtl/time_entry_ctrl_keypad_event.sv
// Keypad front end: synchronises the asynchronous key strobe, produces one
// event per rising edge of it, and decodes the row/column into a key code.
module keypad_event
    import time_entry_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic [1:0] key_row_i,
    input  logic [1:0] key_col_i,
    input  logic      keypad_int_i,
    output logic      key_valid_o,
    output key_code_t key_code_o
);

    logic s1_q;
    logic s2_q;
    logic s2_d_q;

    // Two-flop synchroniser plus one delay flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s2_d_q <= 1'b0;
        end else begin
            s1_q   <= keypad_int_i;
            s2_q   <= s1_q;
            s2_d_q <= s2_q;
        end
    end

    // Row/col are stable by the time the synchronised edge appears, so they
    // are decoded directly; letter keys never produce an event.
    always_comb begin
        key_code_o  = decode_key(key_row_i, key_col_i);
        key_valid_o = s2_q & ~s2_d_q & (key_code_o != KEY_NONE);
    end

endmodule

// File: rtl/time_entry_ctrl.sv
// Sequences four-digit HH:MM entry from the keypad, validates it and issues a
// one-cycle load of the entered time, or flags an entry error.
module time_entry_ctrl
    import time_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ERR_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  key_row,
    input  logic [1:0]  key_col,
    input  logic        keypad_int,
    output logic [15:0] key_buffer,
    output logic [2:0]  digit_count,
    output logic        entry_active,
    output logic        time_load,
    output logic [15:0] time_value,
    output logic        entry_error
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int EW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_CYCLES - 1);

    logic      key_valid;
    key_code_t key_code;

    keypad_event u_keypad_event (
        .clk          (clk),
        .reset        (reset),
        .key_row_i    (key_row),
        .key_col_i    (key_col),
        .keypad_int_i (keypad_int),
        .key_valid_o  (key_valid),
        .key_code_o   (key_code)
    );

    state_t        state_q, state_d;
    logic [15:0]   buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [EW-1:0] err_q, err_d;
    logic [15:0]   tval_q, tval_d;
    logic          load_q, load_d;
    logic          active_q, active_d;
    logic          error_q, error_d;

    // Next-state, buffer and timer logic for the entry sequence
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        tval_d  = tval_q;

        case (state_q)
            IDLE: begin
                if (key_valid && is_digit(key_code)) begin
                    buf_d   = {buf_q[11:0], key_code};
                    cnt_d   = 3'd1;
                    tmo_d   = '0;
                    state_d = ENTRY;
                end
            end

            ENTRY: begin
                if (key_valid) begin
                    // Any accepted key, even an ignored fifth digit, restarts
                    // the inactivity timer and beats a coincident expiry.
                    tmo_d = '0;
                    if (is_digit(key_code)) begin
                        if (cnt_q != FULL_COUNT) begin
                            buf_d = {buf_q[11:0], key_code};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (key_code == KEY_ENTER) begin
                        err_d   = '0;
                        state_d = (cnt_q == FULL_COUNT) ? CHECK : ERROR;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            CHECK: begin
                if (time_is_valid(buf_q)) begin
                    tval_d  = buf_q;
                    state_d = COMMIT;
                end else begin
                    err_d   = '0;
                    state_d = ERROR;
                end
            end

            COMMIT: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end

            ERROR: begin
                // Buffer stays visible while the error is shown
                if (err_q == ERR_LAST) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    state_d = IDLE;
                end else begin
                    err_d = err_q + 1'b1;
                end
            end

            default: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        load_d   = (state_d == COMMIT);
        active_d = (state_d == ENTRY);
        error_d  = (state_d == ERROR);
    end

    // State, buffer, timers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            err_q    <= '0;
            tval_q   <= '0;
            load_q   <= 1'b0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            tval_q   <= tval_d;
            load_q   <= load_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    assign key_buffer   = buf_q;
    assign digit_count  = cnt_q;
    assign entry_active = active_q;
    assign time_load    = load_q;
    assign time_value   = tval_q;
    assign entry_error  = error_q;

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: key-level reference model compared every cycle,
// plus hand-computed checkpoints after each directed key sequence.
module tb_time_entry_ctrl;

    localparam int TIMEOUT = 1000;
    localparam int ERRC    = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  key_row;
    logic [1:0]  key_col;
    logic        keypad_int;
    logic [15:0] key_buffer;
    logic [2:0]  digit_count;
    logic        entry_active;
    logic        time_load;
    logic [15:0] time_value;
    logic        entry_error;

    time_entry_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .ERR_CYCLES(ERRC)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_row      (key_row),
        .key_col      (key_col),
        .keypad_int   (keypad_int),
        .key_buffer   (key_buffer),
        .digit_count  (digit_count),
        .entry_active (entry_active),
        .time_load    (time_load),
        .time_value   (time_value),
        .entry_error  (entry_error)
    );

    always #5 clk = ~clk;

    string layout = "123A456B789C*0#D";

    // ---------------- reference model (key-level view) ----------------
    int          m_mode;   // 0 idle, 1 entering, 2 checking, 3 committing, 4 error
    logic [15:0] m_buf;
    int          m_cnt;
    bit          m_load;
    logic [15:0] m_tval;
    int          m_quiet;
    int          m_errn;
    bit          h1, h2, h3;

    function automatic bit is_dig(input byte c);
        return (c >= "0") && (c <= "9");
    endfunction

    always @(posedge clk) begin
        byte c;
        bit  ev;
        int  hh;
        int  mm;
        if (reset) begin
            m_mode = 0; m_buf = '0; m_cnt = 0; m_load = 0; m_tval = '0;
            m_quiet = 0; m_errn = 0; h1 = 0; h2 = 0; h3 = 0;
        end else begin
            ev = h2 && !h3;
            h3 = h2; h2 = h1; h1 = keypad_int;
            c = ev ? layout[int'({key_row, key_col})] : " ";
            m_load = 0;
            case (m_mode)
                0: if (is_dig(c)) begin
                    m_buf = {m_buf[11:0], 4'(c - "0")}; m_cnt = 1; m_mode = 1; m_quiet = 0;
                end
                1: if (is_dig(c) || c == "*" || c == "#") begin
                    m_quiet = 0;
                    if (is_dig(c)) begin
                        if (m_cnt < 4) begin m_buf = {m_buf[11:0], 4'(c - "0")}; m_cnt++; end
                    end else if (c == "*") begin
                        m_buf = '0; m_cnt = 0; m_mode = 0;
                    end else begin
                        m_errn = 0; m_mode = (m_cnt == 4) ? 2 : 4;
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet >= TIMEOUT) begin m_buf = '0; m_cnt = 0; m_mode = 0; end
                end
                2: begin
                    hh = int'(m_buf[15:12]) * 10 + int'(m_buf[11:8]);
                    mm = int'(m_buf[7:4]) * 10 + int'(m_buf[3:0]);
                    if (hh < 24 && mm < 60) begin m_mode = 3; m_load = 1; m_tval = m_buf; end
                    else begin m_mode = 4; m_errn = 0; end
                end
                3: begin m_buf = '0; m_cnt = 0; m_mode = 0; end
                4: begin
                    m_errn++;
                    if (m_errn >= ERRC) begin m_buf = '0; m_cnt = 0; m_mode = 0; end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // ---------------- checkpoint requests from the stimulus ----------------
    bit          cmp_en = 0;
    int          pin_req = 0;
    string       pin_name;
    logic [15:0] pin_buf;
    int          pin_cnt;
    bit          pin_act;
    int          pin_loads;
    logic [15:0] pin_tval;
    int          pin_errc;

    // ---------------- single compare process ----------------
    int n_checks = 0;
    int n_errs   = 0;
    int n_loads  = 0;
    int n_errc   = 0;
    int pin_ack  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (time_load) n_loads++;
            if (entry_error) n_errc++;
            chk("key_buffer", int'(key_buffer), int'(m_buf));
            chk("digit_count", int'(digit_count), m_cnt);
            chk("entry_active", int'(entry_active), int'(m_mode == 1));
            chk("time_load", int'(time_load), int'(m_load));
            chk("time_value", int'(time_value), int'(m_tval));
            chk("entry_error", int'(entry_error), int'(m_mode == 4));
            if (pin_req != pin_ack) begin
                chk({pin_name, ".buf"}, int'(key_buffer), int'(pin_buf));
                chk({pin_name, ".cnt"}, int'(digit_count), pin_cnt);
                chk({pin_name, ".active"}, int'(entry_active), int'(pin_act));
                chk({pin_name, ".loads"}, n_loads, pin_loads);
                chk({pin_name, ".tval"}, int'(time_value), int'(pin_tval));
                chk({pin_name, ".errcyc"}, n_errc, pin_errc);
                pin_ack = pin_req;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input logic [15:0] b, input int c, input bit a,
                       input int l, input logic [15:0] tv, input int ec);
        pin_name = nm; pin_buf = b; pin_cnt = c; pin_act = a;
        pin_loads = l; pin_tval = tv; pin_errc = ec;
        pin_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic set_key(input byte ch);
        int idx;
        idx = 0;
        for (int i = 0; i < 16; i++) if (layout[i] == ch) idx = i;
        key_row = 2'(idx / 4);
        key_col = 2'(idx % 4);
    endtask

    task automatic press(input byte ch, input int hold);
        set_key(ch);
        keypad_int = 1'b1;
        step(hold);
        keypad_int = 1'b0;
        step(4);
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i], 4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; keypad_int = 1'b0; key_row = '0; key_col = '0;
        step(3);
        cmp_en = 1;
        step(1);
        reset = 1'b0;
        pin("reset", 16'h0000, 0, 0, 0, 16'h0000, 0);

        keys("*#");
        pin("idle_ctl", 16'h0000, 0, 0, 0, 16'h0000, 0);

        press("1", 4); pin("d1", 16'h0001, 1, 1, 0, 16'h0000, 0);
        press("2", 4); pin("d2", 16'h0012, 2, 1, 0, 16'h0000, 0);
        press("3", 4); pin("d3", 16'h0123, 3, 1, 0, 16'h0000, 0);
        press("4", 4); pin("d4", 16'h1234, 4, 1, 0, 16'h0000, 0);
        press("#", 4); pin("load1234", 16'h0000, 0, 0, 1, 16'h1234, 0);

        keys("4380"); pin("e4380", 16'h4380, 4, 1, 1, 16'h1234, 0);
        press("#", 4); pin("err4380", 16'h0000, 0, 0, 1, 16'h1234, 4);

        keys("2359#"); pin("load2359", 16'h0000, 0, 0, 2, 16'h2359, 4);
        keys("2400#"); pin("err2400", 16'h0000, 0, 0, 2, 16'h2359, 8);
        keys("0000#"); pin("load0000", 16'h0000, 0, 0, 3, 16'h0000, 8);

        keys("12#"); pin("err12", 16'h0000, 0, 0, 3, 16'h0000, 12);
        keys("12345"); pin("fifth", 16'h1234, 4, 1, 3, 16'h0000, 12);
        press("*", 4); pin("clear", 16'h0000, 0, 0, 3, 16'h0000, 12);

        // Inactivity timeout boundary: accept edge K, press ends after K+5
        press("9", 4);
        step(TIMEOUT - 6);
        pin("tmo_999", 16'h0009, 1, 1, 3, 16'h0000, 12);
        step(1);
        pin("tmo_1000", 16'h0000, 0, 0, 3, 16'h0000, 12);

        // Second key lands on the 999th cycle after the first
        press("9", 4);
        step(TIMEOUT - 9);
        press("1", 4);
        pin("tmo_key999", 16'h0091, 2, 1, 3, 16'h0000, 12);
        press("*", 4);

        // Held key gives one digit; letter keys are ignored
        press("7", 50); pin("held", 16'h0007, 1, 1, 3, 16'h0000, 12);
        press("A", 4); pin("letterA", 16'h0007, 1, 1, 3, 16'h0000, 12);
        press("*", 4);

        // Reset in the middle of an entry
        keys("12"); pin("pre_rst", 16'h0012, 2, 1, 3, 16'h0000, 12);
        reset = 1'b1;
        step(1);
        pin("mid_rst", 16'h0000, 0, 0, 3, 16'h0000, 12);
        reset = 1'b0;
        step(2);

        // A second '#' arriving during ERROR is dropped
        keys("12");
        set_key("#");
        keypad_int = 1'b1; step(1);
        keypad_int = 1'b0; step(1);
        keypad_int = 1'b1; step(1);
        keypad_int = 1'b0; step(8);
        pin("err_drop", 16'h0000, 0, 0, 3, 16'h0000, 16);
        press("3", 4); pin("after_err", 16'h0003, 1, 1, 3, 16'h0000, 16);

        step(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
